// File: rtl/lock_sequencer_if.sv
// Handshake bundle between the canal-lock sequencer and the lock site:
// boat requests/occupancy in, gate and valve commands plus status out.
interface lock_sequencer_if #(
  parameter int LW = 4
);
  logic [1:0]    arrivReq;
  logic          poundOccu;
  logic [1:0]    gateOpen;
  logic          fillValve;
  logic          drainValve;
  logic [LW-1:0] level;
  logic          busy;
  logic          curSide;

  // master: the lock site (requests, sensors); slave: the sequencer
  modport master (
    output arrivReq, poundOccu,
    input  gateOpen, fillValve, drainValve, level, busy, curSide
  );

  modport slave (
    input  arrivReq, poundOccu,
    output gateOpen, fillValve, drainValve, level, busy, curSide
  );
endinterface

// File: rtl/lock_sequencer.sv
// Two-gate canal lock sequencer: arbitrates low/high-side arrivals, equalizes,
// admits the boat, shifts the pound level and releases it at the far gate.
module lock_sequencer #(
  parameter int LEVEL_MAX = 8,
  parameter int DWELL     = 4,
  parameter int LW        = $clog2(LEVEL_MAX + 1)
) (
  input  logic            clk,
  input  logic            reset,
  lock_sequencer_if.slave bus
);
  localparam int            CW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [LW-1:0] LEVEL_TOP  = LW'(LEVEL_MAX);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] EQ_IN     = 3'd1;
  localparam logic [2:0] OPEN_IN   = 3'd2;
  localparam logic [2:0] DWELL_IN  = 3'd3;
  localparam logic [2:0] SHIFT     = 3'd4;
  localparam logic [2:0] OPEN_OUT  = 3'd5;
  localparam logic [2:0] DWELL_OUT = 3'd6;

  logic [2:0]    state, stateNxt;
  logic [LW-1:0] level, valveTgt;
  logic [CW-1:0] cnt, cntNxt;
  logic          curSide, curSideNxt;
  logic          lastServed, lastServedNxt;
  logic          winSide, moving, atTgt, fill, drain;
  logic [1:0]    gateCmd;

  function automatic logic [LW-1:0] tgt(input logic side);
    return side ? LEVEL_TOP : '0;
  endfunction

  // Single requester wins outright; a tie goes to the side already at level,
  // otherwise alternates away from the side served last.
  always_comb begin
    if (bus.arrivReq == 2'b01)       winSide = 1'b0;
    else if (bus.arrivReq == 2'b10)  winSide = 1'b1;
    else if (level == tgt(1'b0))     winSide = 1'b0;
    else if (level == tgt(1'b1))     winSide = 1'b1;
    else                             winSide = ~lastServed;
  end

  always_comb begin
    valveTgt = (state == SHIFT) ? tgt(~curSide) : tgt(curSide);
    moving   = (state == EQ_IN) || (state == SHIFT);
    atTgt    = (level == valveTgt);
    fill     = moving && (level < valveTgt);
    drain    = moving && (level > valveTgt);
  end

  always_comb begin
    stateNxt      = state;
    cntNxt        = cnt;
    curSideNxt    = curSide;
    lastServedNxt = lastServed;
    case (state)
      IDLE:
        if (bus.arrivReq != 2'b00) begin
          curSideNxt = winSide;
          stateNxt   = (level == tgt(winSide)) ? OPEN_IN : EQ_IN;
        end
      EQ_IN:
        if (!bus.arrivReq[curSide]) stateNxt = IDLE;
        else if (atTgt)             stateNxt = OPEN_IN;
      OPEN_IN:
        if (bus.poundOccu) begin
          stateNxt = DWELL_IN;
          cntNxt   = '0;
        end else if (!bus.arrivReq[curSide]) begin
          stateNxt = IDLE;
        end
      DWELL_IN:
        if (!bus.poundOccu) begin
          stateNxt = OPEN_IN;
        end else if (cnt == DWELL_LAST) begin
          stateNxt      = SHIFT;
          lastServedNxt = curSide;
        end else begin
          cntNxt = cnt + CW'(1);
        end
      SHIFT:
        if (atTgt) stateNxt = OPEN_OUT;
      OPEN_OUT:
        if (!bus.poundOccu) begin
          stateNxt = DWELL_OUT;
          cntNxt   = '0;
        end
      DWELL_OUT:
        if (bus.poundOccu)          stateNxt = OPEN_OUT;
        else if (cnt == DWELL_LAST) stateNxt = IDLE;
        else                        cntNxt   = cnt + CW'(1);
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      level      <= '0;
      cnt        <= '0;
      curSide    <= 1'b0;
      lastServed <= 1'b1;
    end else begin
      state      <= stateNxt;
      cnt        <= cntNxt;
      curSide    <= curSideNxt;
      lastServed <= lastServedNxt;
      if (fill && (level != LEVEL_TOP))  level <= level + LW'(1);
      else if (drain && (level != '0))   level <= level - LW'(1);
    end
  end

  // Entry phases open the served side's gate, exit phases the opposite one.
  always_comb begin
    gateCmd = '0;
    if ((state == OPEN_IN) || (state == DWELL_IN))        gateCmd[curSide]  = 1'b1;
    else if ((state == OPEN_OUT) || (state == DWELL_OUT)) gateCmd[~curSide] = 1'b1;
  end

  assign bus.gateOpen   = gateCmd;
  assign bus.fillValve  = fill;
  assign bus.drainValve = drain;
  assign bus.level      = level;
  assign bus.busy       = (state != IDLE);
  assign bus.curSide    = curSide;
endmodule

// File: tb/tb_lock_sequencer.sv
// Directed bench for lock_sequencer (LEVEL_MAX=4, DWELL=3) with per-cycle
// checks of the gate/valve safety invariants.
module tb_lock_sequencer;
  localparam int LEVEL_MAX = 4;
  localparam int DWELL     = 3;
  localparam int LW        = 3;

  logic clk;
  logic reset;
  int   nTests;
  int   nFail;

  lock_sequencer_if #(.LW(LW)) bus ();

  lock_sequencer #(.LEVEL_MAX(LEVEL_MAX), .DWELL(DWELL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock, then the four safety invariants on the settled outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    nTests += 4;
    if (bus.gateOpen === 2'b11) begin
      nFail++; $display("FAIL inv_two_gates gateOpen=%b required not 11", bus.gateOpen);
    end
    if ((bus.fillValve || bus.drainValve) && (bus.gateOpen !== 2'b00)) begin
      nFail++; $display("FAIL inv_valve_gate fill=%b drain=%b gateOpen=%b required gateOpen 00 while a valve is on",
                        bus.fillValve, bus.drainValve, bus.gateOpen);
    end
    if (bus.fillValve && bus.drainValve) begin
      nFail++; $display("FAIL inv_both_valves fill=1 drain=1 required not both");
    end
    if ((bus.gateOpen[0] && (bus.level !== 3'd0)) || (bus.gateOpen[1] && (bus.level !== 3'd4))) begin
      nFail++; $display("FAIL inv_gate_level gateOpen=%b level=%0d required level of open gate side",
                        bus.gateOpen, bus.level);
    end
  endtask

  // Counts valve-on cycles until a gate opens; -1 if it never does.
  task automatic run_until_gate(output int valveCyc);
    valveCyc = -1;
    for (int i = 0, v = 0; i < 30; i++) begin
      if (bus.gateOpen !== 2'b00) begin
        valveCyc = v;
        break;
      end
      if (bus.fillValve || bus.drainValve) v++;
      tick();
    end
  endtask

  // Ticks until busy=0 (which=0) or the gates close (which=1); -1 on timeout.
  task automatic ticks_until(input int which, output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if ((which == 0 && bus.busy === 1'b0) || (which == 1 && bus.gateOpen === 2'b00)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.arrivReq = 2'b11; bus.poundOccu = 1'b1;
    tick(); tick(); tick();
    nTests++;
    if (bus.gateOpen !== 2'b00 || bus.fillValve !== 1'b0 || bus.drainValve !== 1'b0 ||
        bus.level !== 3'd0 || bus.busy !== 1'b0 || bus.curSide !== 1'b0) begin
      nFail++; $display("FAIL reset_hold gate=%b fill=%b drain=%b level=%0d busy=%b side=%b required all 0",
                        bus.gateOpen, bus.fillValve, bus.drainValve, bus.level, bus.busy, bus.curSide);
    end
    bus.arrivReq = 2'b00; bus.poundOccu = 1'b0; reset = 1'b1;
    tick();
  endtask

  task automatic test_up_bound();
    int n;
    bus.arrivReq = 2'b01;
    tick();
    nTests++;
    if (bus.gateOpen !== 2'b01 || bus.curSide !== 1'b0 || bus.busy !== 1'b1 || bus.fillValve !== 1'b0) begin
      nFail++; $display("FAIL up_grant gate=%b side=%b busy=%b fill=%b required 01 0 1 0",
                        bus.gateOpen, bus.curSide, bus.busy, bus.fillValve);
    end
    bus.poundOccu = 1'b1;
    tick();
    bus.arrivReq = 2'b00;
    ticks_until(1, n);
    nTests++;
    if (n !== DWELL) begin
      nFail++; $display("FAIL up_entry_dwell got %0d more cycles open, required %0d", n, DWELL);
    end
    nTests++;
    if (bus.fillValve !== 1'b1 || bus.level !== 3'd0) begin
      nFail++; $display("FAIL up_shift_start fill=%b level=%0d required 1 0", bus.fillValve, bus.level);
    end
    run_until_gate(n);
    nTests++;
    if (n !== LEVEL_MAX || bus.gateOpen !== 2'b10 || bus.level !== 3'd4) begin
      nFail++; $display("FAIL up_shift fillCycles=%0d gate=%b level=%0d required 4 10 4", n, bus.gateOpen, bus.level);
    end
    bus.poundOccu = 1'b0;
    ticks_until(0, n);
    nTests++;
    if (n !== DWELL + 1 || bus.level !== 3'd4 || bus.gateOpen !== 2'b00) begin
      nFail++; $display("FAIL up_exit ticksToIdle=%0d level=%0d gate=%b required %0d 4 00", n, bus.level, bus.gateOpen, DWELL + 1);
    end
  endtask

  task automatic test_down_bound();
    int n;
    bus.arrivReq = 2'b01;
    tick();
    nTests++;
    if (bus.drainValve !== 1'b1 || bus.gateOpen !== 2'b00 || bus.curSide !== 1'b0 || bus.level !== 3'd4) begin
      nFail++; $display("FAIL down_grant drain=%b gate=%b side=%b level=%0d required 1 00 0 4",
                        bus.drainValve, bus.gateOpen, bus.curSide, bus.level);
    end
    run_until_gate(n);
    nTests++;
    if (n !== 4 || bus.gateOpen !== 2'b01 || bus.level !== 3'd0) begin
      nFail++; $display("FAIL down_equalize drainCycles=%0d gate=%b level=%0d required 4 01 0", n, bus.gateOpen, bus.level);
    end
  endtask

  task automatic test_cancel_open();
    bus.arrivReq = 2'b00;
    tick();
    nTests++;
    if (bus.gateOpen !== 2'b00 || bus.busy !== 1'b0) begin
      nFail++; $display("FAIL cancel_open gate=%b busy=%b required 00 0", bus.gateOpen, bus.busy);
    end
  endtask

  task automatic test_back_out();
    bus.arrivReq = 2'b01;
    tick();
    bus.poundOccu = 1'b1;
    tick(); tick();
    nTests++;
    if (bus.gateOpen !== 2'b01) begin
      nFail++; $display("FAIL backout_dwell gate=%b required 01", bus.gateOpen);
    end
    bus.poundOccu = 1'b0;
    tick(); tick(); tick();
    nTests++;
    if (bus.gateOpen !== 2'b01 || bus.busy !== 1'b1 || bus.fillValve !== 1'b0 || bus.drainValve !== 1'b0) begin
      nFail++; $display("FAIL backout_reopen gate=%b busy=%b fill=%b drain=%b required 01 1 0 0",
                        bus.gateOpen, bus.busy, bus.fillValve, bus.drainValve);
    end
    bus.arrivReq = 2'b00;
    tick();
    nTests++;
    if (bus.busy !== 1'b0) begin
      nFail++; $display("FAIL backout_cancel busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_up_mismatch();
    int n;
    bus.arrivReq = 2'b10;
    tick();
    nTests++;
    if (bus.fillValve !== 1'b1 || bus.curSide !== 1'b1 || bus.gateOpen !== 2'b00) begin
      nFail++; $display("FAIL upmis_grant fill=%b side=%b gate=%b required 1 1 00", bus.fillValve, bus.curSide, bus.gateOpen);
    end
    run_until_gate(n);
    nTests++;
    if (n !== 4 || bus.gateOpen !== 2'b10 || bus.level !== 3'd4) begin
      nFail++; $display("FAIL upmis_equalize fillCycles=%0d gate=%b level=%0d required 4 10 4", n, bus.gateOpen, bus.level);
    end
    bus.arrivReq = 2'b00;
    tick();
    nTests++;
    if (bus.busy !== 1'b0 || bus.level !== 3'd4) begin
      nFail++; $display("FAIL upmis_cancel busy=%b level=%0d required 0 4", bus.busy, bus.level);
    end
  endtask

  task automatic test_arb_match();
    int n;
    bus.arrivReq = 2'b11;
    tick();
    nTests++;
    if (bus.curSide !== 1'b1 || bus.gateOpen !== 2'b10 || bus.fillValve !== 1'b0 || bus.drainValve !== 1'b0) begin
      nFail++; $display("FAIL arb_match side=%b gate=%b fill=%b drain=%b required 1 10 0 0",
                        bus.curSide, bus.gateOpen, bus.fillValve, bus.drainValve);
    end
    bus.poundOccu = 1'b1;
    tick();
    bus.arrivReq = 2'b00;
    ticks_until(1, n);
    run_until_gate(n);
    nTests++;
    if (n !== LEVEL_MAX || bus.gateOpen !== 2'b01 || bus.level !== 3'd0) begin
      nFail++; $display("FAIL arb_match_shift drainCycles=%0d gate=%b level=%0d required 4 01 0", n, bus.gateOpen, bus.level);
    end
    bus.poundOccu = 1'b0;
    ticks_until(0, n);
    nTests++;
    if (n !== DWELL + 1) begin
      nFail++; $display("FAIL arb_match_exit ticksToIdle=%0d required %0d", n, DWELL + 1);
    end
  endtask

  task automatic test_cancel_eq();
    bus.arrivReq = 2'b01;
    tick(); tick();
    nTests++;
    if (bus.level !== 3'd3 || bus.drainValve !== 1'b1) begin
      nFail++; $display("FAIL canceleq_pre level=%0d drain=%b required 3 1", bus.level, bus.drainValve);
    end
    bus.arrivReq = 2'b00;
    tick();
    nTests++;
    if (bus.busy !== 1'b0 || bus.drainValve !== 1'b0 || bus.fillValve !== 1'b0 || bus.level !== 3'd2) begin
      nFail++; $display("FAIL canceleq busy=%b drain=%b fill=%b level=%0d required 0 0 0 2",
                        bus.busy, bus.drainValve, bus.fillValve, bus.level);
    end
    tick(); tick();
    nTests++;
    if (bus.level !== 3'd2) begin
      nFail++; $display("FAIL canceleq_hold level=%0d required 2", bus.level);
    end
  endtask

  task automatic test_arb_tie_back_to_back();
    int n;
    bus.arrivReq = 2'b11;
    tick();
    nTests++;
    if (bus.curSide !== 1'b0 || bus.drainValve !== 1'b1 || bus.gateOpen !== 2'b00) begin
      nFail++; $display("FAIL arb_tie side=%b drain=%b gate=%b required 0 1 00", bus.curSide, bus.drainValve, bus.gateOpen);
    end
    run_until_gate(n);
    nTests++;
    if (n !== 2 || bus.gateOpen !== 2'b01) begin
      nFail++; $display("FAIL arb_tie_equalize drainCycles=%0d gate=%b required 2 01", n, bus.gateOpen);
    end
    bus.poundOccu = 1'b1;
    tick();
    bus.arrivReq = 2'b10;
    ticks_until(1, n);
    run_until_gate(n);
    nTests++;
    if (n !== LEVEL_MAX || bus.gateOpen !== 2'b10 || bus.curSide !== 1'b0) begin
      nFail++; $display("FAIL b2b_shift fillCycles=%0d gate=%b side=%b required 4 10 0", n, bus.gateOpen, bus.curSide);
    end
    bus.poundOccu = 1'b0;
    ticks_until(0, n);
    nTests++;
    if (n !== DWELL + 1) begin
      nFail++; $display("FAIL b2b_exit ticksToIdle=%0d required %0d", n, DWELL + 1);
    end
    tick();
    nTests++;
    if (bus.gateOpen !== 2'b10 || bus.curSide !== 1'b1 || bus.busy !== 1'b1) begin
      nFail++; $display("FAIL b2b_next_grant gate=%b side=%b busy=%b required 10 1 1", bus.gateOpen, bus.curSide, bus.busy);
    end
    bus.arrivReq = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_shift();
    int n;
    bus.arrivReq = 2'b10;
    tick();
    bus.poundOccu = 1'b1;
    tick();
    bus.arrivReq = 2'b00;
    ticks_until(1, n);
    tick(); tick();
    nTests++;
    if (bus.level !== 3'd2 || bus.drainValve !== 1'b1) begin
      nFail++; $display("FAIL midshift_pre level=%0d drain=%b required 2 1", bus.level, bus.drainValve);
    end
    #2 reset = 1'b0;
    #1;
    nTests++;
    if (bus.gateOpen !== 2'b00 || bus.fillValve !== 1'b0 || bus.drainValve !== 1'b0 ||
        bus.level !== 3'd0 || bus.busy !== 1'b0 || bus.curSide !== 1'b0) begin
      nFail++; $display("FAIL midshift_reset gate=%b fill=%b drain=%b level=%0d busy=%b side=%b required all 0",
                        bus.gateOpen, bus.fillValve, bus.drainValve, bus.level, bus.busy, bus.curSide);
    end
    bus.poundOccu = 1'b0;
    tick();
    reset = 1'b1;
    tick(); tick();
    nTests++;
    if (bus.busy !== 1'b0 || bus.level !== 3'd0 || bus.gateOpen !== 2'b00) begin
      nFail++; $display("FAIL midshift_release busy=%b level=%0d gate=%b required 0 0 00", bus.busy, bus.level, bus.gateOpen);
    end
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;
    test_reset();
    test_up_bound();
    test_down_bound();
    test_cancel_open();
    test_back_out();
    test_up_mismatch();
    test_arb_match();
    test_up_mismatch();
    test_cancel_eq();
    test_arb_tie_back_to_back();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
